string_operand_loader: RTL and testbench

Upstream feeder for the string hardware engine on the DE2-115/NIOS2 accelerator path. It accepts operand bytes one at a time from the NIOS2-side bus and packs them into the engine's A/B string registers and lengths. It then drives the engine's `go`/`index` handshake, captures the result when `done` rises, and streams the result back a byte at a time.

---
 rtl/string_hw_pkg.sv | 8 +
 rtl/string_operand_loader_if.sv | 15 +
 rtl/string_byte_buffer.sv | 32 +++
 rtl/string_operand_loader.sv | 95 +++++++++
 tb/tb_string_operand_loader.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/string_hw_pkg.sv
// string_hw_pkg: shared sizes, op codes and types for the string engine feeder.
package string_hw_pkg;
  localparam int MAX_LEN = 16;
  localparam logic [2:0] OP_COMPARE = 3'd0;
  localparam logic [2:0] OP_TO_UPPER = 3'd1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RELEASE} loader_state_t;
  typedef logic [0:MAX_LEN-1][7:0] str_t;
endpackage

// File: rtl/string_operand_loader_if.sv
// string_operand_loader_if: host-side operand writes, control/status and result byte stream.
interface string_operand_loader_if;
  logic clear, wr_valid, wr_ready, wr_sel, start, busy, err_overflow, err_timeout;
  logic res_valid, res_ready, res_last;
  logic [7:0] wr_data, res_data;
  logic [2:0] op_index;
  modport master (
    output clear, wr_valid, wr_sel, wr_data, start, op_index, res_ready,
    input  wr_ready, busy, err_overflow, err_timeout, res_valid, res_data, res_last
  );
  modport slave (
    input  clear, wr_valid, wr_sel, wr_data, start, op_index, res_ready,
    output wr_ready, busy, err_overflow, err_timeout, res_valid, res_data, res_last
  );
endinterface

// File: rtl/string_byte_buffer.sv
// string_byte_buffer: append-only operand byte buffer with length and sticky overflow flag.
module string_byte_buffer #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic wr_en,
  input  logic [7:0] data,
  output logic [0:MAX_LEN-1][7:0] buf_q,
  output logic [LEN_W-1:0] len,
  output logic overflow
);
  logic full;
  assign full = len == LEN_W'(MAX_LEN);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      buf_q <= '0;
      len <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      len <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      if (full) overflow <= 1'b1;
      else begin
        for (int i = 0; i < MAX_LEN; i++) if (len == LEN_W'(i)) buf_q[i] <= data;
        len <= len + 1'b1;
      end
    end
endmodule

// File: rtl/string_operand_loader.sv
// string_operand_loader: packs host operand bytes into the string engine, runs it, streams the result back.
// Optional engine watchdog is compiled in with STRING_LOADER_TIMEOUT_EN.
module string_operand_loader
  import string_hw_pkg::*;
#(
  parameter int MAX_LEN = string_hw_pkg::MAX_LEN,
  parameter int LEN_W = $clog2(MAX_LEN + 1),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  string_operand_loader_if.slave bus,
  output logic eng_go,
  output logic [2:0] eng_index,
  output logic [0:MAX_LEN-1][7:0] eng_A,
  output logic [0:MAX_LEN-1][7:0] eng_B,
  output logic [LEN_W-1:0] eng_lengthA,
  output logic [LEN_W-1:0] eng_lengthB,
  input  logic eng_done,
  input  logic [0:MAX_LEN-1][7:0] eng_result
);
  localparam int IW = $clog2(MAX_LEN);
  loader_state_t state, state_d;
  logic [0:MAX_LEN-1][7:0] res_q;
  logic [IW-1:0] ptr, last_ptr;
  logic idle, clr, wr_en_a, wr_en_b, ovf_a, ovf_b, tmo, empty;
  assign idle = state == IDLE;
  assign clr = idle && bus.clear;
  assign wr_en_a = idle && bus.wr_valid && !bus.wr_sel;
  assign wr_en_b = idle && bus.wr_valid && bus.wr_sel;
  assign empty = eng_index != OP_COMPARE && eng_lengthA == '0;
  string_byte_buffer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_buf_a (
    .clk(clk), .reset(reset), .clear(clr), .wr_en(wr_en_a), .data(bus.wr_data),
    .buf_q(eng_A), .len(eng_lengthA), .overflow(ovf_a)
  );
  string_byte_buffer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_buf_b (
    .clk(clk), .reset(reset), .clear(clr), .wr_en(wr_en_b), .data(bus.wr_data),
    .buf_q(eng_B), .len(eng_lengthB), .overflow(ovf_b)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = bus.start && !eng_done ? RUN : IDLE;
      RUN:     state_d = eng_done ? (empty ? RELEASE : DRAIN) : (tmo ? RELEASE : RUN);
      DRAIN:   state_d = bus.res_ready && ptr == last_ptr ? RELEASE : DRAIN;
      RELEASE: state_d = eng_done ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // A compare returns its verdict in the numeric LSB, i.e. the last element.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      eng_index <= '0;
      res_q <= '0;
      ptr <= '0;
      last_ptr <= '0;
    end else begin
      if (idle && bus.start && !eng_done) eng_index <= bus.op_index;
      if (state == RUN && eng_done) begin
        res_q <= eng_result;
        ptr <= eng_index == OP_COMPARE ? IW'(MAX_LEN - 1) : '0;
        last_ptr <= eng_index == OP_COMPARE ? IW'(MAX_LEN - 1) : IW'(eng_lengthA - 1'b1);
      end else if (state == DRAIN && bus.res_ready && ptr != last_ptr) ptr <= ptr + 1'b1;
    end
  always_comb begin
    eng_go = state == RUN;
    bus.busy = !idle;
    bus.wr_ready = idle;
    bus.res_valid = state == DRAIN;
    bus.res_last = state == DRAIN && ptr == last_ptr;
    bus.res_data = state == DRAIN ? res_q[ptr] : 8'h00;
    bus.err_overflow = ovf_a | ovf_b;
  end
`ifdef STRING_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic err_tmo;
  assign tmo = state == RUN && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign bus.err_timeout = err_tmo;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tmo_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      tmo_cnt <= state == RUN ? tmo_cnt + 1'b1 : '0;
      err_tmo <= clr ? 1'b0 : err_tmo | (tmo && !eng_done);
    end
`else
  assign tmo = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_string_operand_loader.sv
// tb_string_operand_loader: vector table, directed corner cases and random runs against a queue-based model.
module tb_string_operand_loader;
  import string_hw_pkg::*;
  localparam int ML = MAX_LEN;
  localparam int LW = $clog2(ML + 1);
  localparam int TMO = 64;
  logic clk = 1'b0;
  logic reset;
  logic eng_go, eng_done;
  logic [2:0] eng_index;
  str_t eng_A, eng_B, eng_result;
  logic [LW-1:0] eng_lengthA, eng_lengthB;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  string_operand_loader_if bus();
  string_operand_loader #(.MAX_LEN(ML), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .eng_go(eng_go), .eng_index(eng_index), .eng_A(eng_A), .eng_B(eng_B),
    .eng_lengthA(eng_lengthA), .eng_lengthB(eng_lengthB),
    .eng_done(eng_done), .eng_result(eng_result)
  );
  initial forever #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end
  typedef struct {
    logic [2:0] op;
    int na;
    logic [31:0] a;
    int nb;
    logic [31:0] b;
    int lat;
    int hold;
    int stall_at;
    int stall_len;
    int n_exp;
    logic [7:0] first_exp;
  } vec_t;
  vec_t tv [6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  function automatic str_t engine(input logic [2:0] op);
    str_t r;
    logic eq;
    r = '0;
    if (op == OP_COMPARE) begin
      eq = qa.size() == qb.size();
      foreach (qa[i]) if (i < qb.size() && qa[i] != qb[i]) eq = 1'b0;
      r[ML-1] = {7'd0, eq};
    end else
      foreach (qa[i]) r[i] = (op == OP_TO_UPPER && qa[i] >= "a" && qa[i] <= "z") ? qa[i] - 8'h20 : qa[i];
    return r;
  endfunction
  task automatic wr(input logic sel, input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_sel = sel;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    if (sel) begin
      if (qb.size() < ML) qb.push_back(d);
    end else if (qa.size() < ML) qa.push_back(d);
  endtask
  task automatic clr();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    qa.delete();
    qb.delete();
  endtask
  task automatic run_op(input logic [2:0] op, input int lat, input int hold, input int stall_at,
                        input int stall_len, output int n_got, output logic [7:0] first);
    str_t r;
    logic [7:0] exp_q[$];
    logic [7:0] held;
    int go_cnt;
    r = engine(op);
    if (op == OP_COMPARE) exp_q.push_back(r[ML-1]);
    else foreach (qa[i]) exp_q.push_back(r[i]);
    n_got = 0;
    first = 8'h00;
    bus.op_index = op;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_valid = 1'b0;
    bus.clear = 1'b0;
    chk("go_rise", eng_go, 1);
    chk("busy_run", bus.busy, 1);
    chk("wr_ready_run", bus.wr_ready, 0);
    chk("eng_index", eng_index, op);
    chk("lengthA", eng_lengthA, qa.size());
    chk("lengthB", eng_lengthB, qb.size());
    foreach (qa[i]) chk("eng_A", eng_A[i], qa[i]);
    foreach (qb[i]) chk("eng_B", eng_B[i], qb[i]);
    go_cnt = 1;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      go_cnt += int'(eng_go);
    end
    eng_result = r;
    eng_done = 1'b1;
    @(negedge clk);
    chk("go_cycles", go_cnt, lat);
    chk("go_fall", eng_go, 0);
    while (n_got < exp_q.size()) begin
      if (n_got == stall_at && stall_len > 0) begin
        held = bus.res_data;
        bus.res_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          chk("stall_valid", bus.res_valid, 1);
          chk("stall_data", bus.res_data, held);
        end
        bus.res_ready = 1'b1;
      end
      chk("res_valid", bus.res_valid, 1);
      chk("res_data", bus.res_data, exp_q[n_got]);
      chk("res_last", bus.res_last, n_got == exp_q.size() - 1);
      if (n_got == 0) first = bus.res_data;
      n_got++;
      @(negedge clk);
    end
    chk("drain_end_valid", bus.res_valid, 0);
    chk("release_busy", bus.busy, 1);
    repeat (hold) begin
      @(negedge clk);
      chk("release_hold", bus.busy, 1);
    end
    eng_done = 1'b0;
    @(negedge clk);
    chk("back_idle", bus.busy, 0);
    chk("idle_go", eng_go, 0);
  endtask
  initial begin
    int n, na, nb, sa, sl, lat, hold;
    logic [7:0] f;
    logic [2:0] op;
    tv[0] = '{OP_COMPARE, 1, {"8", 24'h0}, 1, {"8", 24'h0}, 2, 0, -1, 0, 1, 8'h01};
    tv[1] = '{OP_TO_UPPER, 2, {"ab", 16'h0}, 0, 32'h0, 3, 0, -1, 0, 2, 8'h41};
    tv[2] = '{OP_COMPARE, 2, {"ab", 16'h0}, 2, {"ac", 16'h0}, 1, 1, -1, 0, 1, 8'h00};
    tv[3] = '{OP_TO_UPPER, 4, "x1y!", 0, 32'h0, 2, 3, 1, 5, 4, 8'h58};
    tv[4] = '{OP_TO_UPPER, 0, 32'h0, 0, 32'h0, 1, 0, -1, 0, 0, 8'h00};
    tv[5] = '{3'd2, 2, {"qz", 16'h0}, 1, {"q", 24'h0}, 4, 2, 0, 2, 2, 8'h71};
    bus.clear = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_sel = 1'b0;
    bus.wr_data = 8'h00;
    bus.start = 1'b0;
    bus.op_index = 3'd0;
    bus.res_ready = 1'b1;
    eng_done = 1'b0;
    eng_result = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_go", eng_go, 0);
    chk("rst_index", eng_index, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_last", bus.res_last, 0);
    chk("rst_data", bus.res_data, 0);
    chk("rst_ovf", bus.err_overflow, 0);
    chk("rst_tmo", bus.err_timeout, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_lenA", eng_lengthA, 0);
    chk("rst_lenB", eng_lengthB, 0);
    reset = 1'b1;
    @(negedge clk);
    foreach (tv[k]) begin
      clr();
      for (int i = 0; i < tv[k].na; i++) wr(1'b0, tv[k].a[31-8*i -: 8]);
      for (int i = 0; i < tv[k].nb; i++) wr(1'b1, tv[k].b[31-8*i -: 8]);
      run_op(tv[k].op, tv[k].lat, tv[k].hold, tv[k].stall_at, tv[k].stall_len, n, f);
      chk("tv_count", n, tv[k].n_exp);
      if (tv[k].n_exp > 0) chk("tv_first", f, tv[k].first_exp);
    end
    run_op(OP_COMPARE, 1, 0, -1, 0, n, f);
    chk("rerun_persist_first", f, 8'h00);
    clr();
    for (int i = 0; i <= ML; i++) wr(1'b0, 8'(i + 'h30));
    chk("ovf_len", eng_lengthA, ML);
    chk("ovf_flag", bus.err_overflow, 1);
    chk("ovf_first", eng_A[0], 8'h30);
    chk("ovf_last_kept", eng_A[ML-1], 8'(ML - 1 + 'h30));
    bus.clear = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_sel = 1'b0;
    bus.wr_data = 8'h55;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.wr_valid = 1'b0;
    qa.delete();
    qb.delete();
    chk("clr_wins_len", eng_lengthA, 0);
    chk("clr_ovf", bus.err_overflow, 0);
    chk("clr_lenB", eng_lengthB, 0);
    wr(1'b0, "a");
    bus.wr_valid = 1'b1;
    bus.wr_sel = 1'b0;
    bus.wr_data = "b";
    qa.push_back("b");
    run_op(OP_TO_UPPER, 2, 0, -1, 0, n, f);
    chk("wr_start_count", n, 2);
    chk("wr_start_first", f, 8'h41);
    wr(1'b1, "z");
    bus.clear = 1'b1;
    qa.delete();
    qb.delete();
    run_op(OP_TO_UPPER, 1, 0, -1, 0, n, f);
    chk("clr_start_count", n, 0);
    eng_done = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_ign_busy", bus.busy, 0);
    chk("start_ign_go", eng_go, 0);
    eng_done = 1'b0;
    @(negedge clk);
    clr();
    wr(1'b0, "k");
    bus.op_index = OP_TO_UPPER;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rst_seq_go", eng_go, 1);
    chk("rst_seq_wr_ready", bus.wr_ready, 0);
    bus.wr_valid = 1'b1;
    bus.wr_data = 8'h7a;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.clear = 1'b0;
    chk("run_ignores_wr", eng_lengthA, 1);
    chk("run_ignores_clr", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("midrst_go", eng_go, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_lenA", eng_lengthA, 0);
    chk("midrst_index", eng_index, 0);
    @(negedge clk);
    reset = 1'b1;
    qa.delete();
    qb.delete();
    @(negedge clk);
`ifdef STRING_LOADER_TIMEOUT_EN
    begin
      int go_cnt, cyc;
      logic seen;
      wr(1'b0, "t");
      bus.op_index = OP_TO_UPPER;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      go_cnt = 0;
      cyc = 0;
      seen = 1'b0;
      while (bus.busy && cyc < TMO + 20) begin
        go_cnt += int'(eng_go);
        seen |= bus.res_valid;
        @(negedge clk);
        cyc++;
      end
      chk("tmo_idle", bus.busy, 0);
      chk("tmo_go_cycles", go_cnt, TMO);
      chk("tmo_flag", bus.err_timeout, 1);
      chk("tmo_no_result", seen, 0);
      clr();
      chk("tmo_clear", bus.err_timeout, 0);
    end
`else
    chk("tmo_tied", bus.err_timeout, 0);
`endif
    for (int it = 0; it < 40; it++) begin
      if (it == 0 || $urandom_range(3) != 0) begin
        clr();
        na = int'($urandom_range(ML));
        for (int i = 0; i < na; i++) wr(1'b0, 8'($urandom_range('h20, 'h7e)));
        if ($urandom_range(1) == 1) foreach (qa[i]) wr(1'b1, qa[i]);
        else begin
          nb = int'($urandom_range(ML));
          for (int i = 0; i < nb; i++) wr(1'b1, 8'($urandom_range('h20, 'h7e)));
        end
      end
      op = 3'($urandom_range(3));
      lat = int'($urandom_range(1, 6));
      hold = int'($urandom_range(3));
      sa = int'($urandom_range(ML));
      sl = int'($urandom_range(4));
      run_op(op, lat, hold, sa, sl, n, f);
      chk("rand_count", n, op == OP_COMPARE ? 1 : qa.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
